memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
Shares the single word-addressed memory port (17-bit address, 32-bit data, 4 byte write enables) between the CPU (requester 0) and up to NUM_REQ-1 IOPs.
- Each requester raises req and receives a registered one-hot grant, which drives that unit's active input.
- The arbiter muxes the owner's address, data and write enables onto the memory, and broadcasts read data.
- Round-robin fairness with a per-tenure quantum.
- A mandatory one-cycle turnaround between owners, because requester bus outputs release to Z.

Parameters:
NUM_REQ, 4, number of requesters; index 0 is the CPU, 1..NUM_REQ-1 are IOPs; range 2..8.
QUANTUM, 8, grant cycles after which the owner may be preempted if another requester is waiting; range 1..255.
ADDR_W, 17, memory word-address width.
DATA_W, 32, memory data width.

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset_n  in  1  asynchronous, active-low reset.
req  in  NUM_REQ  request per requester; level, held while bus is wanted.
grant  out  NUM_REQ  one-hot or zero; drives each requester's active.
req_addr  in  NUM_REQ*ADDR_W  flattened requester addresses; slice i belongs to requester i.
req_wdata  in  NUM_REQ*DATA_W  flattened requester write data.
req_we  in  NUM_REQ*4  flattened requester byte write enables.
mem_addr  out  ADDR_W  address to memory.
mem_wdata  out  DATA_W  write data to memory.
mem_we  out  4  byte write enables to memory.
owner  out  3  index of current grantee; valid only when busy=1.
busy  out  1  high while any grant is asserted.

Behaviour:
- Reset (async, reset_n=0):
  - grant=0, busy=0, owner=0, state=IDLE.
  - rr_ptr=0, qcount=0.
  - mem_addr, mem_wdata and mem_we are all 0.
  - Release is synchronous to the next clock edge.
- States: IDLE, GRANT, TURN.
- IDLE:
  - If req is nonzero, pick the first set req scanning from rr_ptr upward with wrap.
  - Next edge: grant[pick]=1, owner=pick, qcount=0, state=GRANT.
  - Latency from req rising to grant is one clock.
  - No request: stay in IDLE.
- GRANT:
  - qcount increments each cycle and saturates at QUANTUM.
  - If req[owner]=0, go to TURN.
  - Otherwise preempt when all three hold: qcount==QUANTUM, any other req set, and owner's req_we==0 this cycle. Preemption goes to TURN.
  - A nonzero req_we blocks preemption. A write is never cut.
  - If the quantum expires with no other requester, the owner keeps the bus indefinitely.
- TURN (exactly one cycle):
  - grant=0, busy=0, mem_we forced 0.
  - rr_ptr=(owner+1) mod NUM_REQ.
  - Next edge: same arbitration as IDLE, so a new grant can appear directly (GRANT), else IDLE.
  - The previous owner is eligible again only after others at or after rr_ptr.
- Mux (combinational from registered owner/busy):
  - When busy, mem_addr, mem_wdata and mem_we come from slice[owner].
  - Otherwise all are 0.
- Invariants:
  - At most one grant bit is set.
  - grant changes never occur back-to-back between different owners; at least one zero-grant cycle separates them.
  - mem_we is 0 whenever busy=0.
- Simultaneous events:
  - Owner drops req in the same cycle the quantum expires: take the release path, TURN.
  - Requests arriving during TURN are seen at the TURN→GRANT decision.
- Reset mid-grant: grant drops immediately (async) and mem_we goes to 0. No write completion is attempted.

Decomposition:
- Package sigma_mem_pkg holds:
  - ADDR_W=17 and DATA_W=32 constants.
  - the arb_state_t enum {IDLE, GRANT, TURN}.
  - a BYTE_EN_W=4 constant.
- One sub-module, rr_pick: purely combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: pick index and a valid flag.
  - Reused later for the IOP channel scheduler.

Test Plan:
- Single IOP: req[1] rises at cycle 10 with addr 0x2A, wdata 0x32100021, we 0xF.
  - grant=0010 at cycle 11.
  - mem_addr=0x2A and mem_we=0xF while granted.
  - After req[1] falls: one TURN cycle with grant=0, then IDLE.
- Round-robin: req=1111 held constantly, QUANTUM=8, all req_we=0.
  - Grants rotate in order 0,1,2,3,0.
  - Each tenure lasts 9 cycles (8 plus the preempt decision cycle).
  - Each tenure is followed by one zero-grant cycle.
- Write protection: owner 2 holds req_we=0xF continuously from qcount=6 to 12 while req[0]=1.
  - No preemption until the first cycle with req_we=0.
  - mem_we never drops during the write.
- Quantum without contention: only req[3] set for 40 cycles.
  - grant stays 1000 for all 40 cycles with no TURN.
  - qcount saturates at 8.
- Reset mid-operation: assert reset_n=0 while owner=1 and mem_we=0xF.
  - grant=0 and mem_we=0 with no clock.
  - After release with req=0010: grant returns one clock later, rr_ptr starts at 0.
- Boundary: NUM_REQ=2 with req alternating in the same cycle as TURN.
  - Exactly one grant at a time.
  - The pointer wraps from 1 to 0 correctly.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared constants and types for the memory-port arbiter and related schedulers.
package sigma_mem_pkg;

    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 32;
    localparam int BYTE_EN_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping past N-1.
// Purely combinational so it can be shared by other schedulers.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    output logic [2:0]   pick,
    output logic         valid
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        int           idx;
        logic [N-1:0] req_sh;
        idx    = 0;
        req_sh = '0;
        pick   = '0;
        valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            req_sh = req >> idx;
            if (!valid && req_sh[0]) begin
                valid = 1'b1;
                pick  = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbiter for the shared word-addressed memory port: CPU (index 0) plus IOPs.
//
// state | meaning
// IDLE  | no owner; arbitrate every cycle from rr_ptr
// GRANT | owner drives the memory port; quantum counting
// TURN  | one dead cycle so the old owner's bus can float before the next owner
module memory_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int QUANTUM = 8,
    parameter int ADDR_W  = sigma_mem_pkg::ADDR_W,
    parameter int DATA_W  = sigma_mem_pkg::DATA_W
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic [NUM_REQ-1:0]                         req,
    output logic [NUM_REQ-1:0]                         grant,
    input  logic [NUM_REQ*ADDR_W-1:0]                  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]                  req_wdata,
    input  logic [NUM_REQ*sigma_mem_pkg::BYTE_EN_W-1:0] req_we,
    output logic [ADDR_W-1:0]                          mem_addr,
    output logic [DATA_W-1:0]                          mem_wdata,
    output logic [sigma_mem_pkg::BYTE_EN_W-1:0]        mem_we,
    output logic [2:0]                                 owner,
    output logic                                       busy
);

    import sigma_mem_pkg::*;

    localparam logic [7:0]         QMAX = 8'(QUANTUM);
    localparam logic [NUM_REQ-1:0] ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t         state_q, state_d;
    logic [2:0]         owner_q, owner_d;
    logic [7:0]         qcount_q, qcount_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic [2:0]           pick_idx;
    logic                 pick_valid;
    logic                 owner_req;
    logic                 others_req;
    logic [BYTE_EN_W-1:0] owner_we;
    logic [2:0]           next_ptr;

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .pick  (pick_idx),
        .valid (pick_valid)
    );

    // Views of the current owner's request and write enables, and competing demand.
    always_comb begin
        logic [NUM_REQ-1:0]           req_sh;
        logic [NUM_REQ*BYTE_EN_W-1:0] we_sh;
        req_sh     = req >> owner_q;
        we_sh      = req_we >> (int'(owner_q) * BYTE_EN_W);
        owner_req  = req_sh[0];
        owner_we   = we_sh[BYTE_EN_W-1:0];
        others_req = |(req & ~(ONE << owner_q));
        next_ptr   = (owner_q == 3'(NUM_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            qcount_q <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            qcount_q <= qcount_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
        end
    end

    // Next-state: arbitrate from IDLE/TURN, release or preempt from GRANT.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        qcount_d = qcount_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE, TURN: begin
                if (pick_valid) begin
                    state_d  = GRANT;
                    owner_d  = pick_idx;
                    qcount_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                qcount_d = (qcount_q == QMAX) ? qcount_q : qcount_q + 8'd1;
                // A write in progress is never cut, even after the quantum.
                if (!owner_req || (qcount_q == QMAX && others_req && owner_we == '0)) begin
                    state_d  = TURN;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = (state_d == GRANT) ? (ONE << owner_d) : '0;
    end

    // Outputs: registered grant, owner mux onto the memory port only while busy.
    always_comb begin
        logic [NUM_REQ*ADDR_W-1:0]    addr_sh;
        logic [NUM_REQ*DATA_W-1:0]    data_sh;
        logic [NUM_REQ*BYTE_EN_W-1:0] we_sh;
        addr_sh   = req_addr >> (int'(owner_q) * ADDR_W);
        data_sh   = req_wdata >> (int'(owner_q) * DATA_W);
        we_sh     = req_we >> (int'(owner_q) * BYTE_EN_W);
        busy      = (state_q == GRANT);
        grant     = grant_q;
        owner     = owner_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        if (busy) begin
            mem_addr  = addr_sh[ADDR_W-1:0];
            mem_wdata = data_sh[DATA_W-1:0];
            mem_we    = we_sh[BYTE_EN_W-1:0];
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: a 4-requester instance (quantum 8) and a
// 2-requester instance (quantum 2), both checked every cycle against a
// tenure-level model of the arbitration rules.
module tb_memory_arbiter;

    logic        clock;
    logic        reset_n;

    logic [3:0]   req;
    logic [3:0]   grant;
    logic [67:0]  req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_we;
    logic [16:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_we;
    logic [2:0]   owner;
    logic         busy;

    logic [1:0]  req2;
    logic [1:0]  grant2;
    logic [33:0] req_addr2;
    logic [63:0] req_wdata2;
    logic [7:0]  req_we2;
    logic [16:0] mem_addr2;
    logic [31:0] mem_wdata2;
    logic [3:0]  mem_we2;
    logic [2:0]  owner2;
    logic        busy2;

    int n_pass;
    int n_total;

    typedef struct packed {
        int owner;   // -1 when nobody holds the bus
        int tenure;  // granted cycles so far, counting the current one
        int ptr;     // first requester considered at the next arbitration
    } mstate_t;

    mstate_t m1, m2;

    memory_arbiter #(.NUM_REQ(4), .QUANTUM(8)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .grant(grant),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .owner(owner), .busy(busy)
    );

    memory_arbiter #(.NUM_REQ(2), .QUANTUM(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .req(req2), .grant(grant2),
        .req_addr(req_addr2), .req_wdata(req_wdata2), .req_we(req_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2),
        .owner(owner2), .busy(busy2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.owner  = -1;
        r.tenure = 0;
        r.ptr    = 0;
        return r;
    endfunction

    // One clock of the arbitration rules, in tenure terms.
    function automatic mstate_t model_next(mstate_t m, logic [7:0] rq, logic [31:0] we, int n, int q);
        mstate_t     r;
        logic [31:0] we_sh;
        bit          others;
        r      = m;
        others = 1'b0;
        if (m.owner >= 0) begin
            for (int j = 0; j < n; j++) begin
                if (j != m.owner && rq[j]) others = 1'b1;
            end
            we_sh = we >> (4 * m.owner);
            if (!rq[m.owner] || (m.tenure > q && others && we_sh[3:0] == 4'h0)) begin
                r.owner  = -1;
                r.tenure = 0;
                r.ptr    = (m.owner + 1) % n;
            end else begin
                r.tenure = m.tenure + 1;
            end
        end else begin
            for (int k = 0; k < n; k++) begin
                int c;
                c = (m.ptr + k) % n;
                if (r.owner < 0 && rq[c]) begin
                    r.owner  = c;
                    r.tenure = 1;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        logic [67:0]  a_sh;
        logic [127:0] d_sh;
        logic [15:0]  w_sh;
        logic [33:0]  a2_sh;
        logic [63:0]  d2_sh;
        logic [7:0]   w2_sh;
        if (m1.owner >= 0) begin
            a_sh = req_addr >> (17 * m1.owner);
            d_sh = req_wdata >> (32 * m1.owner);
            w_sh = req_we >> (4 * m1.owner);
            chk("grant", 64'(grant), 64'(4'b0001 << m1.owner));
            chk("busy", 64'(busy), 64'd1);
            chk("owner", 64'(owner), 64'(m1.owner));
            chk("mem_addr", 64'(mem_addr), 64'(a_sh[16:0]));
            chk("mem_wdata", 64'(mem_wdata), 64'(d_sh[31:0]));
            chk("mem_we", 64'(mem_we), 64'(w_sh[3:0]));
        end else begin
            chk("grant_idle", 64'(grant), 64'd0);
            chk("busy_idle", 64'(busy), 64'd0);
            chk("mem_we_idle", 64'(mem_we), 64'd0);
            chk("mem_addr_idle", 64'(mem_addr), 64'd0);
            chk("mem_wdata_idle", 64'(mem_wdata), 64'd0);
        end
        if (m2.owner >= 0) begin
            a2_sh = req_addr2 >> (17 * m2.owner);
            d2_sh = req_wdata2 >> (32 * m2.owner);
            w2_sh = req_we2 >> (4 * m2.owner);
            chk("n2_grant", 64'(grant2), 64'(2'b01 << m2.owner));
            chk("n2_owner", 64'(owner2), 64'(m2.owner));
            chk("n2_mem_addr", 64'(mem_addr2), 64'(a2_sh[16:0]));
            chk("n2_mem_wdata", 64'(mem_wdata2), 64'(d2_sh[31:0]));
            chk("n2_mem_we", 64'(mem_we2), 64'(w2_sh[3:0]));
        end else begin
            chk("n2_grant_idle", 64'(grant2), 64'd0);
            chk("n2_busy_idle", 64'(busy2), 64'd0);
            chk("n2_mem_we_idle", 64'(mem_we2), 64'd0);
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle();
        @(negedge clock);
        check_all();
        @(posedge clock);
        m1 = model_next(m1, {4'b0, req}, {16'b0, req_we}, 4, 8);
        m2 = model_next(m2, {6'b0, req2}, {24'b0, req_we2}, 2, 2);
        #1;
    endtask

    task automatic rand_data();
        req_addr   = {$urandom, $urandom, $urandom};
        req_wdata  = {$urandom, $urandom, $urandom, $urandom};
        req_addr2  = {$urandom, $urandom};
        req_wdata2 = {$urandom, $urandom};
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        reset_n    = 1'b0;
        req        = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_we     = '0;
        req2       = '0;
        req_addr2  = '0;
        req_wdata2 = '0;
        req_we2    = '0;
        m1         = model_reset();
        m2         = model_reset();

        // Reset values.
        #22;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        #1;

        for (int i = 0; i < 10; i++) cycle();

        // Single IOP write burst.
        req = 4'b0010;
        req_addr[33:17]  = 17'h0002A;
        req_wdata[63:32] = 32'h32100021;
        req_we[7:4]      = 4'hF;
        cycle();
        chk("iop_grant_latency", 64'(grant), 64'h2);
        chk("iop_mem_addr", 64'(mem_addr), 64'h2A);
        for (int i = 0; i < 5; i++) cycle();
        chk("iop_mem_we", 64'(mem_we), 64'hF);
        req = 4'b0000;
        cycle();
        chk("iop_turn_grant", 64'(grant), 64'd0);
        for (int i = 0; i < 3; i++) cycle();

        // Round-robin under constant full demand, no writes.
        req_we = '0;
        req    = 4'b1111;
        for (int i = 0; i < 52; i++) begin
            rand_data();
            cycle();
        end
        req = '0;
        for (int i = 0; i < 3; i++) cycle();

        // Write protection: owner 2 writes across the quantum while CPU waits.
        req = 4'b0100;
        for (int k = 0; k < 6 && m1.owner != 2; k++) cycle();
        chk("wp_owner", 64'(owner), 64'd2);
        req = 4'b0101;
        for (int i = 0; i < 22; i++) begin
            req_we[11:8] = (m1.owner == 2 && m1.tenure >= 7 && m1.tenure <= 13) ? 4'hF : 4'h0;
            rand_data();
            cycle();
        end
        req    = '0;
        req_we = '0;
        for (int i = 0; i < 3; i++) cycle();

        // Quantum expiry with no contention.
        req = 4'b1000;
        for (int i = 0; i < 40; i++) begin
            req_we[15:12] = 4'($urandom);
            rand_data();
            cycle();
        end
        chk("solo_grant", 64'(grant), 64'h8);
        req    = '0;
        req_we = '0;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            for (int s = 0; s < 4; s++) begin
                req_we[4*s +: 4] = ($urandom_range(2) == 0) ? 4'($urandom) : 4'h0;
            end
            if (m2.owner >= 0 && $urandom_range(2) == 0) begin
                req2 = (m2.owner == 0) ? 2'b10 : 2'b01;
            end else if (m2.owner < 0) begin
                req2 = ~req2;
            end else if ($urandom_range(4) == 0) begin
                req2 = 2'($urandom);
            end
            req_we2 = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h0;
            rand_data();
            cycle();
        end

        // Reset while IOP 1 is writing.
        req     = 4'b0010;
        req_we  = 16'h00F0;
        req2    = '0;
        req_we2 = '0;
        for (int k = 0; k < 20 && m1.owner != 1; k++) cycle();
        cycle();
        chk("pre_rst_mem_we", 64'(mem_we), 64'hF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_grant", 64'(grant), 64'd0);
        chk("async_rst_mem_we", 64'(mem_we), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        m1 = model_reset();
        m2 = model_reset();
        #1;
        cycle();
        chk("post_rst_grant", 64'(grant), 64'h2);
        req = 4'b0011;
        req_we = '0;
        for (int i = 0; i < 30; i++) cycle();
        req = '0;
        for (int i = 0; i < 3; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
